// File: rtl/timer_responder_if.sv
// Register-bus interface between the system bridge and a timer responder.
// The bridge drives address/write side; the timer returns data and IRQ.
interface timer_responder_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       Addr;
    logic             WE;
    logic [WIDTH-1:0] DIn;
    logic [WIDTH-1:0] DOut;
    logic             IRQ;

    modport master (
        output Addr,
        output WE,
        output DIn,
        input  DOut,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DIn,
        output DOut,
        output IRQ
    );
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload modes and a maskable registered IRQ.
module timer_responder #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    timer_responder_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    state_t           state, state_n;
    logic [3:0]       ctrl, ctrl_n;
    logic [WIDTH-1:0] preset, preset_n;
    logic [WIDTH-1:0] count, count_n;
    logic             irq_flag, irq_flag_n;

    logic enable;
    logic auto_reload;
    logic im;

    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign im          = ctrl[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            preset   <= preset_n;
            count    <= count_n;
            irq_flag <= irq_flag_n;
        end
    end

    always_comb begin
        state_n    = state;
        ctrl_n     = ctrl;
        preset_n   = preset;
        count_n    = count;
        irq_flag_n = irq_flag;

        unique case (state)
            IDLE: begin
                if (enable)
                    state_n = LOAD;
            end
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (count > WIDTH'(1)) begin
                    count_n = count - WIDTH'(1);
                end else begin
                    count_n    = '0;
                    irq_flag_n = 1'b1;
                    state_n    = INT;
                    if (!auto_reload)
                        ctrl_n[0] = 1'b0;
                end
            end
            INT: begin
                state_n = IDLE;
                if (auto_reload)
                    irq_flag_n = 1'b0;
            end
        endcase

        // CPU writes land after the FSM so they win on a shared edge.
        if (bus.WE) begin
            case (bus.Addr)
                2'd0: begin
                    ctrl_n     = bus.DIn[3:0];
                    irq_flag_n = 1'b0;
                end
                2'd1: begin
                    preset_n   = bus.DIn;
                    irq_flag_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.DOut = '0;
        case (bus.Addr)
            2'd0:    bus.DOut = {{(WIDTH-4){1'b0}}, ctrl};
            2'd1:    bus.DOut = preset;
            2'd2:    bus.DOut = count;
            default: bus.DOut = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & im;
endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: stimulus queues expected reads,
// a monitor pops and compares them against DOut/IRQ.
module tb_timer_responder;
    localparam int WIDTH = 32;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] dout;
        logic             irq;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    event sb_kick;

    timer_responder_if #(.WIDTH(WIDTH)) bus ();

    timer_responder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // Monitor: compares every queued expectation at the falling edge,
    // or immediately when kicked for between-edge checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sb_kick);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.DOut !== e.dout || bus.IRQ !== e.irq) begin
                    errors++;
                    $display("FAIL %s: DOut=%h IRQ=%b, expected DOut=%h IRQ=%b",
                             e.name, bus.DOut, bus.IRQ, e.dout, e.irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [WIDTH-1:0] d,
                        input logic i);
        exp_t e;
        e.name = n;
        e.dout = d;
        e.irq  = i;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
        bus.Addr = a;
        bus.DIn  = d;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
    endtask

    task automatic chk(input string n, input logic [1:0] a,
                       input logic [WIDTH-1:0] d, input logic i);
        bus.Addr = a;
        push(n, d, i);
        tick();
    endtask

    task automatic now_chk(input string n, input logic [1:0] a,
                           input logic [WIDTH-1:0] d, input logic i);
        bus.Addr = a;
        #1;
        push(n, d, i);
        ->sb_kick;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        bus.Addr = 2'd0;
        bus.WE   = 1'b0;
        bus.DIn  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset values and register readback
        chk("rst_ctrl", 2'd0, 32'h0, 1'b0);
        chk("rst_preset", 2'd1, 32'h0, 1'b0);
        chk("rst_count", 2'd2, 32'h0, 1'b0);
        chk("rst_unmapped", 2'd3, 32'h0, 1'b0);
        wr(2'd1, 32'h5);
        chk("preset_rd", 2'd1, 32'h5, 1'b0);
        wr(2'd2, 32'h77);
        chk("count_ro", 2'd2, 32'h0, 1'b0);
        wr(2'd3, 32'hFFFF_FFFF);
        chk("unmapped_wr", 2'd3, 32'h0, 1'b0);
        chk("ctrl_upper", 2'd0, 32'h0, 1'b0);

        // One-shot expiry
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("os_cnt3", 2'd2, 32'd3, 1'b0);
        chk("os_cnt2", 2'd2, 32'd2, 1'b0);
        chk("os_cnt1", 2'd2, 32'd1, 1'b0);
        chk("os_cnt0", 2'd2, 32'd0, 1'b1);
        chk("os_ctrl", 2'd0, 32'h8, 1'b1);
        chk("os_hold", 2'd0, 32'h8, 1'b1);
        wr(2'd0, 32'h0);
        chk("os_clear", 2'd0, 32'h0, 1'b0);

        // Auto-reload: period 5 with a one-cycle IRQ
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            case (i % 5)
                0: chk("ar_seq", 2'd2, 32'd2, 1'b0);
                1: chk("ar_seq", 2'd2, 32'd1, 1'b0);
                2: chk("ar_seq", 2'd2, 32'd0, 1'b1);
                default: chk("ar_seq", 2'd2, 32'd0, 1'b0);
            endcase
        end
        wr(2'd0, 32'h0);
        tick();

        // Masked expiry, then unmask via write that clears the flag
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick();
        tick();
        chk("mask_cnt2", 2'd2, 32'd2, 1'b0);
        chk("mask_cnt1", 2'd2, 32'd1, 1'b0);
        chk("mask_cnt0", 2'd2, 32'd0, 1'b0);
        chk("mask_ctrl", 2'd0, 32'h0, 1'b0);
        wr(2'd0, 32'h8);
        chk("unmask_a", 2'd0, 32'h8, 1'b0);
        chk("unmask_b", 2'd0, 32'h8, 1'b0);

        // Disable mid-count freezes COUNT
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("dis_cnt10", 2'd2, 32'd10, 1'b0);
        chk("dis_cnt9", 2'd2, 32'd9, 1'b0);
        chk("dis_cnt8", 2'd2, 32'd8, 1'b0);
        wr(2'd0, 32'h0);
        chk("freeze_a", 2'd2, 32'd6, 1'b0);
        chk("freeze_b", 2'd2, 32'd6, 1'b0);
        chk("freeze_c", 2'd2, 32'd6, 1'b0);
        chk("freeze_ctrl", 2'd0, 32'h0, 1'b0);

        // Restart from new PRESET; a mid-count PRESET write waits for LOAD
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("rs_cnt4", 2'd2, 32'd4, 1'b0);
        wr(2'd1, 32'd7);
        chk("rs_cnt2", 2'd2, 32'd2, 1'b0);
        chk("rs_cnt1", 2'd2, 32'd1, 1'b0);
        chk("rs_cnt0", 2'd2, 32'd0, 1'b1);
        chk("rs_preset", 2'd1, 32'd7, 1'b1);
        wr(2'd0, 32'h0);
        chk("rs_clear", 2'd0, 32'h0, 1'b0);

        // PRESET=0: IRQ three cycles after the Enable write
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        chk("p0_c0", 2'd0, 32'h9, 1'b0);
        chk("p0_c1", 2'd0, 32'h9, 1'b0);
        chk("p0_c2", 2'd0, 32'h9, 1'b0);
        chk("p0_irq", 2'd0, 32'h8, 1'b1);
        wr(2'd0, 32'h0);

        // CTRL write on the expiry edge wins and clears the flag
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick();
        tick();
        wr(2'd0, 32'h9);
        chk("col_int", 2'd0, 32'h9, 1'b0);
        chk("col_idle", 2'd0, 32'h9, 1'b0);
        chk("col_load", 2'd0, 32'h9, 1'b0);
        chk("col_cnt", 2'd2, 32'd1, 1'b0);
        chk("col_irq", 2'd0, 32'h8, 1'b1);
        wr(2'd0, 32'h0);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("ar_cnt5", 2'd2, 32'd5, 1'b0);
        chk("ar_cnt4", 2'd2, 32'd4, 1'b0);
        now_chk("pre_rst_cnt3", 2'd2, 32'd3, 1'b0);
        reset = 1'b0;
        now_chk("async_cnt", 2'd2, 32'd0, 1'b0);
        now_chk("async_ctrl", 2'd0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        chk("post_rst_preset", 2'd1, 32'h0, 1'b0);

        // Asynchronous reset with IRQ high
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        now_chk("pre_rst_irq", 2'd0, 32'h8, 1'b1);
        reset = 1'b0;
        now_chk("async_irq", 2'd0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        chk("post_rst_ctrl", 2'd0, 32'h0, 1'b0);

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0",
                     sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
